line_edit_buffer: RTL and testbench

//  Parametrised successor of the 4-digit keypad entry path.
//  - Holds an N_POS-character edit line with a cursor, and accepts ASCII key codes over a valid/ready handshake.
//  - Supports overwrite, delete-at-cursor, backspace, cursor moves, enter (line emit) and clear.
//  - Drives one BCD nibble per position to the display drivers.

---
 rtl/line_edit_buffer.sv | 230 +++++++++++++++++++++++
 tb/tb_line_edit_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_edit_buffer.sv
// line_edit_buffer
//   N_POS-character edit line with a cursor, fed by ASCII key codes over a
//   valid/ready handshake. Supports overwrite, delete-at-cursor, backspace,
//   cursor left/right, enter (emits the line for one cycle) and clear.
//   Each position is also shown as a BCD nibble (4'hF = blank/non-digit).
//
//   Optional feature macro: INSERT_MODE_EN
//     defined   -> tab (0x09) toggles insert mode; digits in insert mode
//                  shift the tail right one char per cycle before writing;
//                  extra output insert_mode.
//     undefined -> overwrite only, tab is an ignored code.
//
// Ports
//   clk, Reset_n          clock (rising edge), async active-low reset
//   key_valid/key_code    ASCII key offer
//   key_ready             key accepted when key_valid & key_ready
//   clear_disp            synchronous clear, beats everything except reset
//   disp_bcd              position i on bits [4i+3:4i], registered
//   cursor_pos            current cursor index, registered
//   line_valid            one-cycle pulse on enter
//   line_data, line_len   raw ASCII line and non-blank count, valid with line_valid
//   insert_mode           (INSERT_MODE_EN only) 1 = insert, 0 = overwrite

// Per-position ASCII -> BCD display cell.
module line_edit_digit (
  input  logic [7:0] ch,
  output logic [3:0] bcd
);
  always_comb begin
    bcd = 4'hF;
    if (ch >= 8'h30 && ch <= 8'h39) bcd = ch[3:0];
  end
endmodule

module line_edit_buffer #(
  parameter int N_POS = 4,
  parameter int CUR_W = $clog2(N_POS)
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 key_valid,
  input  logic [7:0]           key_code,
  output logic                 key_ready,
  input  logic                 clear_disp,
  output logic [4*N_POS-1:0]   disp_bcd,
  output logic [CUR_W-1:0]     cursor_pos,
  output logic                 line_valid,
  output logic [8*N_POS-1:0]   line_data,
  output logic [CUR_W:0]       line_len
`ifdef INSERT_MODE_EN
  ,
  output logic                 insert_mode
`endif
);

  localparam logic [CUR_W-1:0] LAST    = CUR_W'(N_POS - 1);
  localparam logic [7:0]       BLANK   = 8'h20;
  localparam logic [7:0]       K_LEFT  = 8'h02;
  localparam logic [7:0]       K_RIGHT = 8'h06;
  localparam logic [7:0]       K_BS    = 8'h08;
  localparam logic [7:0]       K_ENTER = 8'h0D;
  localparam logic [7:0]       K_DEL   = 8'h7F;
`ifdef INSERT_MODE_EN
  localparam logic [7:0]       K_TAB   = 8'h09;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHL  = 2'd1,
    EMIT = 2'd2
`ifdef INSERT_MODE_EN
    ,
    SHR  = 2'd3
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         buf_q [N_POS];
  logic [7:0]         buf_d [N_POS];
  logic [CUR_W-1:0]   cur_q, cur_d;
  logic [CUR_W-1:0]   idx_q, idx_d, idx_nx;
  logic [4*N_POS-1:0] disp_q, disp_d;
  logic               accept, is_digit;
`ifdef INSERT_MODE_EN
  logic [7:0]         key_q, key_d;
  logic               ins_q, ins_d;
  logic [CUR_W-1:0]   idx_pv;
  assign idx_pv      = idx_q - 1'b1;
  assign insert_mode = ins_q;
`endif

  function automatic logic [CUR_W-1:0] inc_sat(input logic [CUR_W-1:0] c);
    return (c == LAST) ? c : c + 1'b1;
  endfunction

  assign key_ready = (state_q == IDLE) && !clear_disp;
  assign accept    = key_valid && key_ready;
  assign is_digit  = (key_code >= 8'h30) && (key_code <= 8'h39);
  assign idx_nx    = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
`ifdef INSERT_MODE_EN
    key_d   = key_q;
    ins_d   = ins_q;
`endif
    if (clear_disp) begin
      // Drops any shift or pending key; insert mode survives a clear.
      for (int i = 0; i < N_POS; i++) buf_d[i] = BLANK;
      cur_d   = '0;
      idx_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (is_digit) begin
`ifdef INSERT_MODE_EN
            // At the last position there is nothing to shift, so write directly.
            if (ins_q && cur_q != LAST) begin
              key_d   = key_code;
              idx_d   = LAST;
              state_d = SHR;
            end else begin
              buf_d[cur_q] = key_code;
              cur_d        = inc_sat(cur_q);
            end
`else
            buf_d[cur_q] = key_code;
            cur_d        = inc_sat(cur_q);
`endif
          end else begin
            case (key_code)
              K_LEFT:  if (cur_q != '0) cur_d = cur_q - 1'b1;
              K_RIGHT: cur_d = inc_sat(cur_q);
              K_DEL: begin
                idx_d   = cur_q;
                state_d = SHL;
              end
              K_BS: if (cur_q != '0) begin
                cur_d   = cur_q - 1'b1;
                idx_d   = cur_q - 1'b1;
                state_d = SHL;
              end
              K_ENTER: state_d = EMIT;
`ifdef INSERT_MODE_EN
              K_TAB:   ins_d = !ins_q;
`endif
              default: ;
            endcase
          end
        end
        SHL: begin
          if (idx_q == LAST) begin
            buf_d[LAST] = BLANK;
            state_d     = IDLE;
          end else begin
            buf_d[idx_q] = buf_q[idx_nx];
            idx_d        = idx_nx;
          end
        end
`ifdef INSERT_MODE_EN
        SHR: begin
          // The final move (idx = cur+1) also drops the pending key in place.
          buf_d[idx_q] = buf_q[idx_pv];
          if (idx_pv == cur_q) begin
            buf_d[cur_q] = key_q;
            cur_d        = inc_sat(cur_q);
            state_d      = IDLE;
          end else begin
            idx_d = idx_pv;
          end
        end
`endif
        EMIT: begin
          for (int i = 0; i < N_POS; i++) buf_d[i] = BLANK;
          cur_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Display nibbles are decoded from the next buffer so the registered
  // disp_bcd lines up with the buffer register every cycle.
  for (genvar g = 0; g < N_POS; g++) begin : g_pos
    line_edit_digit u_dig (.ch(buf_d[g]), .bcd(disp_d[4*g +: 4]));
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '1;
      for (int i = 0; i < N_POS; i++) buf_q[i] <= BLANK;
`ifdef INSERT_MODE_EN
      key_q   <= '0;
      ins_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      buf_q   <= buf_d;
`ifdef INSERT_MODE_EN
      key_q   <= key_d;
      ins_q   <= ins_d;
`endif
    end
  end

  assign disp_bcd   = disp_q;
  assign cursor_pos = cur_q;
  assign line_valid = (state_q == EMIT);

  always_comb begin
    line_data = '0;
    line_len  = '0;
    for (int i = 0; i < N_POS; i++) begin
      line_data[8*i +: 8] = buf_q[i];
      if (buf_q[i] != BLANK) line_len = line_len + 1'b1;
    end
  end

endmodule

// File: tb/tb_line_edit_buffer.sv
// Bench for line_edit_buffer (N_POS=4). A queue-based model applies each
// accepted key as a whole-line edit and tracks how many cycles the block
// stays busy; a compare process checks the DUT against it every cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_line_edit_buffer;
  localparam int N    = 4;
  localparam int LAST = N - 1;

  logic         clk = 1'b0;
  logic         Reset_n;
  logic         key_valid;
  logic [7:0]   key_code;
  logic         key_ready;
  logic         clear_disp;
  logic [4*N-1:0] disp_bcd;
  logic [1:0]   cursor_pos;
  logic         line_valid;
  logic [8*N-1:0] line_data;
  logic [2:0]   line_len;
`ifdef INSERT_MODE_EN
  logic         insert_mode;
`endif

  line_edit_buffer #(.N_POS(N)) dut (
    .clk(clk), .Reset_n(Reset_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .clear_disp(clear_disp), .disp_bcd(disp_bcd),
    .cursor_pos(cursor_pos), .line_valid(line_valid), .line_data(line_data),
    .line_len(line_len)
`ifdef INSERT_MODE_EN
    , .insert_mode(insert_mode)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]   m_buf[$];
  int           m_cur   = 0;
  int           m_shown = 0;   // cursor visible while busy
  int           m_busy  = 0;   // cycles left with key_ready low
  bit           m_emit  = 0;
  bit           m_ins   = 0;
  logic [8*N-1:0] m_line;
  int           m_len;

  function automatic void m_clear();
    m_buf = {};
    for (int i = 0; i < N; i++) m_buf.push_back(8'h20);
    m_cur = 0; m_shown = 0; m_busy = 0; m_emit = 0;
  endfunction

  function automatic logic [4*N-1:0] exp_disp();
    logic [4*N-1:0] r;
    logic [7:0] b;
    for (int i = 0; i < N; i++) begin
      b = m_buf[i];
      if (b >= 8'h30 && b <= 8'h39) begin
        b = b - 8'h30;
        r[4*i +: 4] = b[3:0];
      end else r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  function automatic void m_key(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      if (m_ins && m_cur != LAST) begin
        m_buf.insert(m_cur, c);
        void'(m_buf.pop_back());
        m_shown = m_cur;
        m_busy  = LAST - m_cur;
        m_cur++;
      end else begin
        m_buf[m_cur] = c;
        if (m_cur < LAST) m_cur++;
      end
    end else case (c)
      8'h02: if (m_cur > 0) m_cur--;
      8'h06: if (m_cur < LAST) m_cur++;
      8'h7F: begin
        m_buf.delete(m_cur); m_buf.push_back(8'h20);
        m_shown = m_cur; m_busy = N - m_cur;
      end
      8'h08: if (m_cur > 0) begin
        m_cur--;
        m_buf.delete(m_cur); m_buf.push_back(8'h20);
        m_shown = m_cur; m_busy = N - m_cur;
      end
      8'h0D: begin
        m_len = 0;
        for (int i = 0; i < N; i++) begin
          m_line[8*i +: 8] = m_buf[i];
          if (m_buf[i] != 8'h20) m_len++;
        end
        m_emit = 1; m_busy = 1; m_shown = m_cur;
        for (int i = 0; i < N; i++) m_buf[i] = 8'h20;
        m_cur = 0;
      end
`ifdef INSERT_MODE_EN
      8'h09: m_ins = !m_ins;
`endif
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_clear(); m_ins = 0;
    end else if (clear_disp) m_clear();
    else if (m_busy != 0) begin
      m_busy--;
      m_emit = 0;
    end else if (key_valid) m_key(key_code);
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("key_ready", key_ready, (m_busy == 0) && !clear_disp);
      chk("line_valid", line_valid, m_emit);
      chk("cursor_pos", cursor_pos, (m_busy != 0) ? m_shown : m_cur);
      if (m_busy == 0) chk("disp_bcd", disp_bcd, exp_disp());
      if (m_emit) begin
        chk("line_data", line_data, m_line);
        chk("line_len", line_len, m_len);
      end
`ifdef INSERT_MODE_EN
      chk("insert_mode", insert_mode, m_ins);
`endif
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_idle();
    int n = 0;
    while (!key_ready && n < 64) begin @(negedge clk); #1; n++; end
    chk("idle_wait", key_ready, 1'b1);
  endtask

  task automatic send_key(input logic [7:0] c);
    int n = 0;
    @(negedge clk); key_valid = 1'b1; key_code = c; #1;
    while (!key_ready && n < 64) begin @(negedge clk); #1; n++; end
    chk("accept_wait", key_ready, 1'b1);
    if (!key_ready) begin key_valid = 1'b0; return; end
    @(negedge clk); key_valid = 1'b0; #1;
  endtask

  task automatic clear_pulse();
    @(negedge clk); clear_disp = 1'b1;
    @(negedge clk); clear_disp = 1'b0; #1;
  endtask

  task automatic type_line(input string s);
    for (int i = 0; i < s.len(); i++) send_key(s[i]);
  endtask

  initial begin
    int n;
    key_valid = 0; key_code = 8'h00; clear_disp = 0; Reset_n = 1'b1;
    #3 Reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_disp", disp_bcd, 16'hFFFF);
    chk("rst_cur", cursor_pos, 2'd0);
    chk("rst_ready", key_ready, 1'b1);
    chk("rst_lv", line_valid, 1'b0);
    @(negedge clk); Reset_n = 1'b1; chk_en = 1;

    // 1: overwrite with saturating cursor
    type_line("12345");
    chk("t1_disp", disp_bcd, 16'h5321);
    chk("t1_cur", cursor_pos, 2'd3);
    send_key(8'h06);                       // right at last position
    send_key(8'h41);                       // unknown code
`ifndef INSERT_MODE_EN
    send_key(8'h09);                       // tab is unknown here
`endif
    chk("t1_hold", disp_bcd, 16'h5321);

    // 2: delete at cursor
    clear_pulse();
    type_line("1234");
    send_key(8'h02); send_key(8'h02);
    chk("t2_cur0", cursor_pos, 2'd1);
    send_key(8'h7F);
    n = 0;
    while (!key_ready && n < 20) begin n++; @(negedge clk); #1; end
    chk("t2_busy", n, 3);
    chk("t2_disp", disp_bcd, 16'hF431);
    chk("t2_cur", cursor_pos, 2'd1);

    // 3: backspace, and backspace at 0
    clear_pulse();
    type_line("12");
    send_key(8'h08);
    wait_idle();
    chk("t3_disp", disp_bcd, 16'hFFF1);
    chk("t3_cur", cursor_pos, 2'd1);
    send_key(8'h02);
    send_key(8'h08);
    chk("t3_ready0", key_ready, 1'b1);
    chk("t3_disp0", disp_bcd, 16'hFFF1);
    chk("t3_cur0", cursor_pos, 2'd0);

    // 4: enter
    clear_pulse();
    type_line("12");
    send_key(8'h06);
    send_key("4");
    chk("t4_pre", disp_bcd, 16'h4F21);
    send_key(8'h0D);
    chk("t4_lv", line_valid, 1'b1);
    chk("t4_data", line_data, 32'h3420_3231);
    chk("t4_len", line_len, 3'd3);
    @(negedge clk); #1;
    chk("t4_lv_off", line_valid, 1'b0);
    chk("t4_disp", disp_bcd, 16'hFFFF);
    chk("t4_cur", cursor_pos, 2'd0);

    // 5: clear during a shift
    type_line("1234");
    send_key(8'h02); send_key(8'h02); send_key(8'h02);
    send_key(8'h7F);
    clear_disp = 1'b1; #1;
    chk("t5_ready_clr", key_ready, 1'b0);
    @(negedge clk); clear_disp = 1'b0; #1;
    chk("t5_disp", disp_bcd, 16'hFFFF);
    chk("t5_cur", cursor_pos, 2'd0);
    chk("t5_ready", key_ready, 1'b1);
    chk("t5_lv", line_valid, 1'b0);

`ifdef INSERT_MODE_EN
    // 6: insert mode
    send_key(8'h09);
    chk("t6_ins", insert_mode, 1'b1);
    type_line("123");
    wait_idle();
    send_key(8'h02); send_key(8'h02);
    send_key("9");
    wait_idle();
    chk("t6_disp", disp_bcd, 16'h3291);
    chk("t6_cur", cursor_pos, 2'd2);
    send_key("8");
    wait_idle();
    chk("t6_full", disp_bcd, 16'h2891);
    chk("t6_cur_full", cursor_pos, 2'd3);
`endif

    // 7: reset in the middle of a shift
    wait_idle();
    clear_pulse();
    type_line("12");
    send_key(8'h02);
    send_key(8'h7F);
    Reset_n = 1'b0; #1;
    chk("t7_disp", disp_bcd, 16'hFFFF);
    chk("t7_cur", cursor_pos, 2'd0);
    chk("t7_ready", key_ready, 1'b1);
`ifdef INSERT_MODE_EN
    chk("t7_ins", insert_mode, 1'b0);
`endif
    @(negedge clk); Reset_n = 1'b1;
    type_line("7");
    chk("t7_after", disp_bcd, 16'hFFF7);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
